phase_seq: RTL
==============

PHASE_SEQ -- requirements
Module: phase_seq

Interface
REQ-001 The block SHALL have parameter NPH, default 4, giving the number of phase-duration table entries (power of two, 2..16).
REQ-002 The block SHALL have parameter DW, default 16, giving the duration and counter width in bits.
REQ-003 The block SHALL have parameter PW, default $clog2(NPH), giving the phase-index width.
REQ-004 The block SHALL have port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port cfg_we  input  1  duration-table write strobe.
REQ-007 The block SHALL have port cfg_addr  input  PW  duration-table write index.
REQ-008 The block SHALL have port cfg_data  input  DW  duration value: the phase lasts cfg_data+1 cycles.
REQ-009 The block SHALL have port num_ph  input  PW  last phase index used (number of phases minus 1).
REQ-010 The block SHALL have port loops  input  8  number of passes through the phases; 0 means run until stopped.
REQ-011 The block SHALL have port start  input  1  one-cycle request to begin a sequence.
REQ-012 The block SHALL have port stop  input  1  one-cycle request to abort a sequence.
REQ-013 The block SHALL have port busy  output  1  high while in RUN.
REQ-014 The block SHALL have port phase  output  PW  current phase index.
REQ-015 The block SHALL have port phase_cnt  output  DW  cycle count within the current phase.
REQ-016 The block SHALL have port phase_tick  output  1  high on the final cycle of each phase.
REQ-017 The block SHALL have port done  output  1  one-cycle pulse marking normal completion.

Function
REQ-018 The block SHALL hold an NPH x DW duration table dur[]; when cfg_we is high and busy is low, dur[cfg_addr] SHALL take cfg_data on the next edge.
REQ-019 The block SHALL ignore cfg_we while busy is high.
REQ-020 The block SHALL implement a two-state FSM with states IDLE and RUN.
REQ-021 In IDLE, start=1 with stop=0 SHALL move the FSM to RUN on the next edge, with phase=0, phase_cnt=0 and pass counter=0.
REQ-022 On that same edge, num_ph and loops SHALL be captured into internal registers; later changes to num_ph or loops SHALL have no effect until the next start.
REQ-023 In IDLE, start and stop both high SHALL leave the FSM in IDLE.
REQ-024 In RUN, start SHALL be ignored.
REQ-025 In RUN, phase_tick SHALL be combinational and equal busy AND (phase_cnt == dur[phase]).
REQ-026 In RUN with phase_tick=0, phase_cnt SHALL increment by 1 each cycle.
REQ-027 In RUN with phase_tick=1, phase_cnt SHALL be cleared to 0 on the next edge.
REQ-028 On a tick with phase < captured num_ph, phase SHALL increment by 1.
REQ-029 On a tick with phase == captured num_ph, phase SHALL wrap to 0 and the 8-bit pass counter SHALL increment, wrapping modulo 256.
REQ-030 done SHALL be combinational and equal phase_tick AND (phase == captured num_ph) AND (captured loops != 0) AND (pass counter == captured loops - 1) AND NOT stop.
REQ-031 On the edge following done=1, the FSM SHALL enter IDLE, with phase, phase_cnt and pass counter cleared to 0.
REQ-032 In RUN, stop=1 SHALL force IDLE on the next edge and clear phase, phase_cnt and pass counter to 0, without asserting done.
REQ-033 stop SHALL take priority over a coincident final tick: done stays 0, while phase_tick still follows REQ-025.
REQ-034 A duration of 0 SHALL yield a one-cycle phase with phase_tick held high for that cycle.
REQ-035 With captured loops=0, the sequence SHALL repeat indefinitely and done SHALL never assert.
REQ-036 In IDLE, phase_tick and done SHALL be 0, and phase and phase_cnt SHALL hold 0.
REQ-037 Start-to-done latency SHALL be loops x sum over i=0..num_ph of (dur[i]+1) cycles, counted from the first RUN cycle through the done cycle inclusive.

Reset
REQ-038 Asserting rst_n low SHALL, asynchronously, force IDLE and set busy=0, phase=0, phase_cnt=0, pass counter=0, captured num_ph=0 and captured loops=0.
REQ-039 During reset, phase_tick and done SHALL be 0.
REQ-040 Reset SHALL clear all dur[] entries to 0.
REQ-041 Reset asserted mid-RUN SHALL abort the sequence with no done pulse.
REQ-042 After rst_n deasserts, the FSM SHALL remain in IDLE until a start is sampled.

Verification
REQ-043 The bench SHALL cover: dur={2,0,3,1}, num_ph=3, loops=1, start -> phase sequence 0,0,0,1,2,2,2,2,3,3; phase_tick high on cycles 3,4,8,10; done on cycle 10; busy low on cycle 11.
REQ-044 The bench SHALL cover: dur={1,1,x,x}, num_ph=1, loops=2 -> 8 RUN cycles and done on cycle 8 only.
REQ-045 The bench SHALL cover: loops=0 running for 100 cycles, then stop -> busy low on the next cycle, done never asserted, and phase and phase_cnt at 0.
REQ-046 The bench SHALL cover: stop coincident with the final tick -> phase_tick=1, done=0, and the FSM in IDLE on the next cycle.
REQ-047 The bench SHALL cover: cfg_we with cfg_addr=0 and cfg_data=9 while busy -> dur[0] unchanged; the same write while idle -> next run's phase 0 lasts 10 cycles.
REQ-048 The bench SHALL cover: rst_n pulsed low mid-phase 2 -> all outputs 0 immediately, dur[] all 0, and no done pulse.

Source files
------------

// File: rtl/phase_seq_if.sv
// Configuration, control and status bundle for the phase sequencer.
interface phase_seq_if #(
   parameter int NPH = 4,
   parameter int DW  = 16,
   parameter int PW  = $clog2(NPH)
);
   logic          cfg_we;
   logic [PW-1:0] cfg_addr;
   logic [DW-1:0] cfg_data;
   logic [PW-1:0] num_ph;
   logic [7:0]    loops;
   logic          start;
   logic          stop;
   logic          busy;
   logic [PW-1:0] phase;
   logic [DW-1:0] phase_cnt;
   logic          phase_tick;
   logic          done;

   modport master (
      output cfg_we, cfg_addr, cfg_data, num_ph, loops, start, stop,
      input  busy, phase, phase_cnt, phase_tick, done
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_data, num_ph, loops, start, stop,
      output busy, phase, phase_cnt, phase_tick, done
   );
endinterface

// File: rtl/phase_seq.sv
// Programmable phase sequencer: steps through num_ph+1 phases of dur[i]+1
// cycles each, for a captured number of passes (0 = free-running).
module phase_seq #(
   parameter int NPH = 4,
   parameter int DW  = 16,
   parameter int PW  = $clog2(NPH)
) (
   input  logic        clk,
   input  logic        rst_n,
   phase_seq_if.slave  bus
);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]    state;
   logic [DW-1:0] dur [NPH];
   logic [PW-1:0] phase_q, num_ph_q;
   logic [DW-1:0] cnt_q;
   logic [7:0]    pass_q, loops_q;

   logic busy, tick, last_ph, done;

   assign busy    = (state == S_RUN);
   assign tick    = busy && (cnt_q == dur[phase_q]);
   assign last_ph = (phase_q == num_ph_q);
   // stop wins over a coincident final tick, so done is masked by it
   assign done    = tick && last_ph && (loops_q != 8'd0) &&
                    (pass_q == loops_q - 8'd1) && !bus.stop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         phase_q  <= '0;
         cnt_q    <= '0;
         pass_q   <= '0;
         num_ph_q <= '0;
         loops_q  <= '0;
         for (int i = 0; i < NPH; i++) dur[i] <= '0;
      end else begin
         if (!busy && bus.cfg_we) dur[bus.cfg_addr] <= bus.cfg_data;
         case (state)
            S_IDLE: begin
               if (bus.start && !bus.stop) begin
                  state    <= S_RUN;
                  phase_q  <= '0;
                  cnt_q    <= '0;
                  pass_q   <= '0;
                  num_ph_q <= bus.num_ph;
                  loops_q  <= bus.loops;
               end
            end
            default: begin
               if (bus.stop || done) begin
                  state   <= S_IDLE;
                  phase_q <= '0;
                  cnt_q   <= '0;
                  pass_q  <= '0;
               end else if (tick) begin
                  cnt_q <= '0;
                  if (last_ph) begin
                     phase_q <= '0;
                     pass_q  <= pass_q + 8'd1;
                  end else begin
                     phase_q <= phase_q + PW'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + DW'(1);
               end
            end
         endcase
      end
   end

   assign bus.busy       = busy;
   assign bus.phase      = phase_q;
   assign bus.phase_cnt  = cnt_q;
   assign bus.phase_tick = tick;
   assign bus.done       = done;
endmodule
